// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter and sequencer sharing one ALU between N requesters.
// Grants one requester, pulses ALU start, waits for done or watchdog, then acks.
module alu_req_arbiter #(
    parameter  int unsigned N       = 4,
    parameter  int unsigned TIMEOUT = 16,
    localparam int unsigned BITS    = $clog2(N),
    localparam int unsigned TW      = $clog2(TIMEOUT + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N-1:0]    i_req,
    input  logic            i_alu_done,
    output logic [N-1:0]    o_gnt,
    output logic [BITS-1:0] o_gnt_idx,
    output logic            o_busy,
    output logic            o_alu_start,
    output logic [N-1:0]    o_ack,
    output logic            o_timeout,
    output logic [7:0]      o_err_cnt
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e          state_q;
    logic [BITS-1:0] last_q;
    logic [TW-1:0]   timer_q;
    logic            to_flag_q;

    logic [BITS-1:0] pick_idx;
    logic [N-1:0]    pick_oh;
    logic            pick_found;

    // Scan last+1, last+2, ... mod N and take the first active request.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            logic [BITS-1:0] cand;
            cand = BITS'((32'(last_q) + i) % N);
            if (!pick_found && i_req[cand]) begin
                pick_idx   = cand;
                pick_found = 1'b1;
            end
        end
        pick_oh = {{(N-1){1'b0}}, 1'b1} << pick_idx;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            o_gnt       <= '0;
            o_gnt_idx   <= '0;
            o_busy      <= 1'b0;
            o_alu_start <= 1'b0;
            o_ack       <= '0;
            o_timeout   <= 1'b0;
            o_err_cnt   <= 8'd0;
            timer_q     <= '0;
            to_flag_q   <= 1'b0;
            last_q      <= BITS'(N - 1);
        end else begin
            o_alu_start <= 1'b0;
            o_ack       <= '0;
            o_timeout   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        o_gnt       <= pick_oh;
                        o_gnt_idx   <= pick_idx;
                        o_busy      <= 1'b1;
                        o_alu_start <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    timer_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    // Done has priority over a simultaneous watchdog expiry.
                    if (i_alu_done) begin
                        o_ack   <= o_gnt;
                        state_q <= StDone;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        o_ack     <= o_gnt;
                        o_timeout <= 1'b1;
                        to_flag_q <= 1'b1;
                        if (o_err_cnt != 8'hFF) begin
                            o_err_cnt <= o_err_cnt + 8'd1;
                        end
                        state_q <= StDone;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StDone: begin
                    last_q    <= o_gnt_idx;
                    o_gnt     <= '0;
                    o_busy    <= 1'b0;
                    to_flag_q <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter (N=4, TIMEOUT=16).
module tb_alu_req_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       alu_done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       alu_start;
    logic [3:0] ack;
    logic       timeout;
    logic [7:0] err_cnt;

    int total  = 0;
    int failed = 0;

    alu_req_arbiter #(.N(4), .TIMEOUT(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_alu_done  (alu_done),
        .o_gnt       (gnt),
        .o_gnt_idx   (gnt_idx),
        .o_busy      (busy),
        .o_alu_start (alu_start),
        .o_ack       (ack),
        .o_timeout   (timeout),
        .o_err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full transaction from IDLE with done raised on the first WAIT cycle.
    task automatic txn(input string tag, input logic [3:0] eg, input logic [1:0] ei);
        tick();
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
        chk({tag, ".start"}, 32'(alu_start), 32'd1);
        tick();
        chk({tag, ".start_off"}, 32'(alu_start), 32'd0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk({tag, ".ack"}, 32'(ack), 32'(eg));
        chk({tag, ".to"}, 32'(timeout), 32'd0);
        tick();
        chk({tag, ".idle"}, {gnt, 3'b0, busy, ack}, 32'd0);
    endtask

    int pulses;

    initial begin
        rst_n    = 1'b0;
        req      = 4'b0000;
        alu_done = 1'b0;
        tick();
        tick();
        chk("rst.outs", {gnt, gnt_idx, busy, alu_start, ack, timeout, err_cnt}, 32'd0);
        rst_n = 1'b1;

        // Round-robin wrap
        req = 4'b1111;
        txn("rr0", 4'b0001, 2'd0);
        txn("rr1", 4'b0010, 2'd1);
        txn("rr2", 4'b0100, 2'd2);
        txn("rr3", 4'b1000, 2'd3);
        txn("rr4", 4'b0001, 2'd0);

        // Sparse / skip: bring last to 1, then 1001
        txn("sp_setup", 4'b0010, 2'd1);
        req = 4'b1001;
        txn("sp0", 4'b1000, 2'd3);
        txn("sp1", 4'b0001, 2'd0);

        // Spurious done in IDLE
        req      = 4'b0000;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("spur.idle", {busy, ack, alu_start}, 32'd0);
        // Spurious done in ISSUE, then drop request in WAIT
        req = 4'b0100;
        tick();
        chk("spur.issue_gnt", 32'(gnt), 32'(4'b0100));
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("spur.issue_ignored", {busy, ack}, 32'(5'b10000));
        req = 4'b0000;
        tick();
        chk("drop.wait", {busy, ack}, 32'(5'b10000));
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("drop.ack", 32'(ack), 32'(4'b0100));
        tick();
        chk("drop.idle", 32'(busy), 32'd0);

        // Timeout: last=2, req 0010
        req = 4'b0010;
        tick();
        chk("to.gnt", 32'(gnt), 32'(4'b0010));
        tick();
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ack != 4'b0000) pulses++;
        end
        chk("to.no_early_ack", 32'(pulses), 32'd0);
        tick();
        chk("to.ack", 32'(ack), 32'(4'b0010));
        chk("to.flag", 32'(timeout), 32'd1);
        req = 4'b0000;
        tick();
        chk("to.err1", 32'(err_cnt), 32'd1);
        chk("to.flag_off", 32'(timeout), 32'd0);

        // Done coincident with expiry: done wins
        req = 4'b0010;
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("tie.ack", 32'(ack), 32'(4'b0010));
        chk("tie.flag", 32'(timeout), 32'd0);
        req = 4'b0000;
        tick();
        chk("tie.err", 32'(err_cnt), 32'd1);

        // Saturation: 260 forced timeouts, 19 cycles each from IDLE
        req    = 4'b0001;
        pulses = 0;
        for (int i = 0; i < 260 * 19; i++) begin
            tick();
            if (timeout) pulses++;
        end
        req = 4'b0000;
        tick();
        chk("sat.pulses", 32'(pulses), 32'd260);
        chk("sat.err", 32'(err_cnt), 32'd255);

        // Async reset mid-WAIT, then restart from requester 0
        req = 4'b1111;
        tick();
        tick();
        chk("rst2.in_wait", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2.outs", {gnt, gnt_idx, busy, alu_start, ack, timeout, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn("rst2.regrant", 4'b0001, 2'd0);

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end

endmodule
